alu_core: RTL and testbench
===========================

# alu_core

Registered 8-bit ALU that serves as the design under test for the ALU verification environment. It samples the driver-side stimulus (ce, mode, cin, cmd, inp_valid, opa, opb) and returns res and the flags err, oflow, cout, g, l and e. Operands may arrive in separate cycles, with a bounded wait for the missing one. Multiply commands take an extra pipeline stage.

## Interface
- WIDTH, 8, operand width; res is 2*WIDTH
- CMD_WIDTH, 4, command width
- TIMEOUT, 16, maximum cycles to wait for a missing operand
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- ce  in  1  clock enable; 0 freezes all state and outputs
- mode  in  1  1 = arithmetic, 0 = logical
- cin  in  1  carry-in for ADD_CIN/SUB_CIN
- cmd  in  CMD_WIDTH  operation select
- inp_valid  in  2  bit0 = opa valid, bit1 = opb valid
- opa, opb  in  WIDTH  operands
- res  out  2*WIDTH  result, zero-extended
- err  out  1  illegal command, missing operand, timeout or bad rotate amount
- oflow  out  1  borrow on subtract, or signed-style overflow per command
- cout  out  1  carry out of add commands
- g, l, e  out  1  compare flags (CMP only)

## Operation
- Arithmetic commands (mode=1):
  - 0 ADD, 1 SUB, 2 ADD_CIN, 3 SUB_CIN: need both operands.
  - 4 INC_A, 5 DEC_A: need opa only.
  - 6 INC_B, 7 DEC_B: need opb only.
  - 8 CMP: needs both.
  - 9 MUL_INC computes (opa+1)*(opb+1); 10 MUL_SHL computes (opa<<1)*opb. Both need both operands.
  - cmd 11–15: err=1, res=0.
- Logical commands (mode=0):
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR: need both operands.
  - 6 NOT_A, 8 SHR1_A, 9 SHL1_A: need opa only.
  - 7 NOT_B, 10 SHR1_B, 11 SHL1_B: need opb only.
  - 12 ROL_A_B, 13 ROR_A_B: rotate opa by opb[2:0]. If any of opb[7:4] is nonzero, err=1 but res still carries the rotate.
  - cmd 14–15: err=1, res=0.
- Width rules:
  - Adds produce WIDTH+1 bits; cout is bit WIDTH.
  - SUB/SUB_CIN: res = low WIDTH bits of opa-opb(-cin); oflow=1 if opa < opb(+cin).
  - Multiply results use the full 2*WIDTH bits.
  - Logical and shift results occupy the low WIDTH bits.
- CMP: res=0 and exactly one of g/l/e is set. All other commands drive g=l=e=0.
- States:
  - IDLE:
    - inp_valid=00: err=1 on the next cycle.
    - Required operands all present: execute; go to MUL for multiplies, otherwise stay in IDLE.
    - Two-operand command with one operand present: latch the present operand plus cmd, mode and cin; clear the wait counter; go to WAIT.
  - WAIT:
    - Each ce=1 cycle increments the counter; cmd/mode changes are ignored.
    - Missing operand arrives: latch it, then execute (or go to MUL).
    - Counter reaches TIMEOUT with no operand: err=1, res=0, return to IDLE.
  - MUL: second stage of the multiply; the result is written, then return to IDLE. Inputs presented during MUL are ignored.
- Outputs change only on a completion event (result, error or timeout) and otherwise hold their last value. Every completion event rewrites all outputs; flags not produced by the command are 0.

## Timing
- Reset: res=0, err=oflow=cout=g=l=e=0, state=IDLE, counter=0. Reset wins over ce and takes effect even mid-WAIT or mid-MUL.
- Latency from the cycle the last required operand is sampled:
  - Non-multiply: outputs valid after the next posedge (1 cycle).
  - Multiply: 2 cycles.
- Timeout: err asserts TIMEOUT+1 cycles after the partial sample, provided ce stays 1.
- ce=0: state, counter and outputs all hold; input samples are discarded.
- In WAIT, if the missing operand arrives on the same cycle the counter reaches TIMEOUT, the operand wins and the command executes.
- Back-to-back non-multiply commands are accepted every cycle.

## Structure
- alu_pkg holds:
  - arith_cmd_e and logic_cmd_e enums;
  - state_e {IDLE, WAIT, MUL};
  - TIMEOUT_DEFAULT;
  - a function returning the required-operand mask per {mode, cmd}.
- Sub-module alu_exec: combinational datapath taking latched operands, cmd, mode and cin and returning res and flags. alu_core holds the FSM, operand latches, wait counter and multiply stage register.

## Test plan
- mode=1, cmd=0, opa=FF, opb=01, inp_valid=11 -> next cycle res=0100, cout=1, err=0.
- mode=1, cmd=9, opa=3, opb=4 -> two cycles later res=20 (0014). A stimulus applied during the MUL cycle is ignored.
- mode=1, cmd=0, opa=5 with inp_valid=01, then 3 cycles of 00, then opb=7 with inp_valid=10 -> res=12 one cycle later, err=0.
- inp_valid=01 with cmd=0, then 00 held -> err=1 exactly 17 cycles after the first sample, res=0. Repeat with ce=0 for 5 cycles mid-wait -> err arrives 5 cycles later.
- mode=1, cmd=8, opa=opb=9 -> e=1, g=l=0, res=0. mode=0, cmd=12, opa=81, opb=01 -> res=0003, err=0. Same command with opb=10 -> err=1.
- rst=1 asserted during WAIT and during MUL -> all outputs 0 next cycle, state IDLE. A subsequent ADD of 2+3 returns res=5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and helpers for the registered ALU.
// Command encodings, FSM states and operand-requirement lookup.
package alu_pkg;

  localparam int TIMEOUT_DEFAULT = 16;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_A    = 2'b01;
  localparam logic [1:0] OP_B    = 2'b10;
  localparam logic [1:0] OP_AB   = 2'b11;

  typedef enum logic [3:0] {
    A_ADD     = 4'd0,
    A_SUB     = 4'd1,
    A_ADD_CIN = 4'd2,
    A_SUB_CIN = 4'd3,
    A_INC_A   = 4'd4,
    A_DEC_A   = 4'd5,
    A_INC_B   = 4'd6,
    A_DEC_B   = 4'd7,
    A_CMP     = 4'd8,
    A_MUL_INC = 4'd9,
    A_MUL_SHL = 4'd10
  } arith_cmd_e;

  typedef enum logic [3:0] {
    L_AND     = 4'd0,
    L_NAND    = 4'd1,
    L_OR      = 4'd2,
    L_NOR     = 4'd3,
    L_XOR     = 4'd4,
    L_XNOR    = 4'd5,
    L_NOT_A   = 4'd6,
    L_NOT_B   = 4'd7,
    L_SHR1_A  = 4'd8,
    L_SHL1_A  = 4'd9,
    L_SHR1_B  = 4'd10,
    L_SHL1_B  = 4'd11,
    L_ROL_A_B = 4'd12,
    L_ROR_A_B = 4'd13
  } logic_cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    MUL  = 2'd2
  } state_e;

  // Illegal commands need nothing, so any sample completes them with err.
  function automatic logic [1:0] req_ops(
    input logic       mode,
    input logic [3:0] cmd
  );
    logic [1:0] m;
    m = OP_NONE;
    if (mode) begin
      case (cmd)
        A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN,
        A_CMP, A_MUL_INC, A_MUL_SHL: m = OP_AB;
        A_INC_A, A_DEC_A:            m = OP_A;
        A_INC_B, A_DEC_B:            m = OP_B;
        default:                     m = OP_NONE;
      endcase
    end else begin
      case (cmd)
        L_AND, L_NAND, L_OR, L_NOR, L_XOR,
        L_XNOR, L_ROL_A_B, L_ROR_A_B:  m = OP_AB;
        L_NOT_A, L_SHR1_A, L_SHL1_A:   m = OP_A;
        L_NOT_B, L_SHR1_B, L_SHL1_B:   m = OP_B;
        default:                       m = OP_NONE;
      endcase
    end
    return m;
  endfunction

  function automatic logic is_mul(
    input logic       mode,
    input logic [3:0] cmd
  );
    return mode && (cmd == A_MUL_INC || cmd == A_MUL_SHL);
  endfunction

endpackage

// File: rtl/alu_exec.sv
// Combinational ALU datapath: result and flags for one command.
// Operands, cmd, mode and cin are already selected by alu_core.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               mode,
  input  logic               cin,
  input  logic [3:0]         cmd,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] res,
  output logic               err,
  output logic               oflow,
  output logic               cout,
  output logic               g,
  output logic               l,
  output logic               e
);

  localparam logic [WIDTH:0] ONE1 =
    {{WIDTH{1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE2 =
    {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH:0]       ax, bx, cx, sum;
  logic [2*WIDTH-1:0]   aw, bw;
  logic [WIDTH-1:0]     lo;
  logic [2:0]           sh;
  logic                 add_op, sub_op;

  always_comb begin
    res    = '0;
    err    = 1'b0;
    oflow  = 1'b0;
    cout   = 1'b0;
    g      = 1'b0;
    l      = 1'b0;
    e      = 1'b0;
    sum    = '0;
    lo     = '0;
    add_op = 1'b0;
    sub_op = 1'b0;
    sh     = b[2:0];
    ax     = {1'b0, a};
    bx     = {1'b0, b};
    cx     = {{WIDTH{1'b0}}, cin};
    aw     = {{WIDTH{1'b0}}, a};
    bw     = {{WIDTH{1'b0}}, b};
    if (mode) begin
      case (cmd)
        A_ADD:     begin sum = ax + bx;      add_op = 1'b1; end
        A_ADD_CIN: begin sum = ax + bx + cx; add_op = 1'b1; end
        A_SUB:     begin sum = ax - bx;      sub_op = 1'b1; end
        A_SUB_CIN: begin sum = ax - bx - cx; sub_op = 1'b1; end
        A_INC_A:   begin sum = ax + ONE1;    add_op = 1'b1; end
        A_DEC_A:   begin sum = ax - ONE1;    sub_op = 1'b1; end
        A_INC_B:   begin sum = bx + ONE1;    add_op = 1'b1; end
        A_DEC_B:   begin sum = bx - ONE1;    sub_op = 1'b1; end
        A_CMP: begin
          g = (a > b);
          l = (a < b);
          e = (a == b);
        end
        A_MUL_INC: res = (aw + ONE2) * (bw + ONE2);
        A_MUL_SHL: res = (aw << 1) * bw;
        default:   err = 1'b1;
      endcase
      // The extra bit of a difference is set exactly when it borrowed.
      if (add_op) begin
        res  = {{(WIDTH-1){1'b0}}, sum};
        cout = sum[WIDTH];
      end
      if (sub_op) begin
        res   = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
        oflow = sum[WIDTH];
      end
    end else begin
      case (cmd)
        L_AND:    lo = a & b;
        L_NAND:   lo = ~(a & b);
        L_OR:     lo = a | b;
        L_NOR:    lo = ~(a | b);
        L_XOR:    lo = a ^ b;
        L_XNOR:   lo = ~(a ^ b);
        L_NOT_A:  lo = ~a;
        L_NOT_B:  lo = ~b;
        L_SHR1_A: lo = a >> 1;
        L_SHL1_A: lo = a << 1;
        L_SHR1_B: lo = b >> 1;
        L_SHL1_B: lo = b << 1;
        L_ROL_A_B: begin
          lo  = (a << sh) | (a >> (WIDTH - int'(sh)));
          err = |b[WIDTH-1:4];
        end
        L_ROR_A_B: begin
          lo  = (a >> sh) | (a << (WIDTH - int'(sh)));
          err = |b[WIDTH-1:4];
        end
        default:  err = 1'b1;
      endcase
      res = {{WIDTH{1'b0}}, lo};
    end
  end

endmodule

// File: rtl/alu_core.sv
// Registered ALU: operand-gathering FSM, wait timer, multiply stage.
// Outputs only move on a completion event and hold otherwise.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 mode,
  input  logic                 cin,
  input  logic [CMD_WIDTH-1:0] cmd,
  input  logic [1:0]           inp_valid,
  input  logic [WIDTH-1:0]     opa,
  input  logic [WIDTH-1:0]     opb,
  output logic [2*WIDTH-1:0]   res,
  output logic                 err,
  output logic                 oflow,
  output logic                 cout,
  output logic                 g,
  output logic                 l,
  output logic                 e
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
  logic                 mode_q, mode_d;
  logic                 cin_q, cin_d;
  logic [1:0]           have_q, have_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic [5:0]           fl_q, fl_d;

  logic                 x_mode, x_cin;
  logic [CMD_WIDTH-1:0] x_cmd;
  logic [WIDTH-1:0]     x_a, x_b;
  logic [2*WIDTH-1:0]   x_res;
  logic [5:0]           x_fl;
  logic [1:0]           need, miss;
  logic                 do_exec, do_fault, do_mul;

  // In WAIT the latched side wins; MUL always uses its stage copy.
  always_comb begin
    x_mode = mode;
    x_cin  = cin;
    x_cmd  = cmd;
    x_a    = opa;
    x_b    = opb;
    if (state_q != IDLE) begin
      x_mode = mode_q;
      x_cin  = cin_q;
      x_cmd  = cmd_q;
      x_a    = (state_q == MUL || have_q[0]) ? a_q : opa;
      x_b    = (state_q == MUL || have_q[1]) ? b_q : opb;
    end
  end

  alu_exec #(
    .WIDTH (WIDTH)
  ) u_exec (
    .mode  (x_mode),
    .cin   (x_cin),
    .cmd   (x_cmd),
    .a     (x_a),
    .b     (x_b),
    .res   (x_res),
    .err   (x_fl[5]),
    .oflow (x_fl[4]),
    .cout  (x_fl[3]),
    .g     (x_fl[2]),
    .l     (x_fl[1]),
    .e     (x_fl[0])
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    cmd_d    = cmd_q;
    mode_d   = mode_q;
    cin_d    = cin_q;
    have_d   = have_q;
    res_d    = res_q;
    fl_d     = fl_q;
    do_exec  = 1'b0;
    do_fault = 1'b0;
    do_mul   = 1'b0;
    need     = req_ops(mode, cmd);
    miss     = ~have_q;
    if (ce) begin
      case (state_q)
        IDLE: begin
          if (inp_valid == OP_NONE) begin
            do_fault = 1'b1;
          end else if ((inp_valid & need) == need) begin
            if (is_mul(mode, cmd)) do_mul  = 1'b1;
            else                   do_exec = 1'b1;
          end else if (need == OP_AB) begin
            a_d     = opa;
            b_d     = opb;
            cmd_d   = cmd;
            mode_d  = mode;
            cin_d   = cin;
            have_d  = inp_valid;
            cnt_d   = '0;
            state_d = WAIT;
          end else begin
            do_fault = 1'b1;
          end
        end
        WAIT: begin
          if ((inp_valid & miss) == miss) begin
            if (is_mul(mode_q, cmd_q)) do_mul  = 1'b1;
            else                       do_exec = 1'b1;
          end else if (cnt_q == TMO) begin
            do_fault = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        MUL:     do_exec = 1'b1;
        default: state_d = IDLE;
      endcase
    end
    if (do_exec) begin
      res_d   = x_res;
      fl_d    = x_fl;
      state_d = IDLE;
    end
    if (do_fault) begin
      res_d   = '0;
      fl_d    = 6'b100000;
      state_d = IDLE;
    end
    if (do_mul) begin
      a_d     = x_a;
      b_d     = x_b;
      cmd_d   = x_cmd;
      mode_d  = x_mode;
      cin_d   = x_cin;
      state_d = MUL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cmd_q   <= '0;
      mode_q  <= 1'b0;
      cin_q   <= 1'b0;
      have_q  <= OP_NONE;
      res_q   <= '0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cmd_q   <= cmd_d;
      mode_q  <= mode_d;
      cin_q   <= cin_d;
      have_q  <= have_d;
      res_q   <= res_d;
      fl_q    <= fl_d;
    end
  end

  assign res = res_q;
  assign {err, oflow, cout, g, l, e} = fl_q;

endmodule

// File: tb/tb_alu_core.sv
// Randomised self-checking bench for alu_core.
// Expected values come from an integer-arithmetic reference model.
module tb_alu_core;

  logic       clk = 1'b0;
  logic       rst, ce, mode, cin;
  logic [3:0] cmd;
  logic [1:0] inp_valid;
  logic [7:0] opa, opb;
  logic [15:0] res;
  logic       err, oflow, cout, g, l, e;
  logic [21:0] obs;
  logic [21:0] prev_exp;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  alu_core u_dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .mode      (mode),
    .cin       (cin),
    .cmd       (cmd),
    .inp_valid (inp_valid),
    .opa       (opa),
    .opb       (opb),
    .res       (res),
    .err       (err),
    .oflow     (oflow),
    .cout      (cout),
    .g         (g),
    .l         (l),
    .e         (e)
  );

  assign obs = {res, err, oflow, cout, g, l, e};

  task automatic chk(input string tag,
                     input logic [21:0] got,
                     input logic [21:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic res_chk(input string tag, input logic [21:0] exp);
    chk(tag, obs, exp);
    prev_exp = exp;
  endtask

  function automatic logic [21:0] model(input bit m, input int c,
                                        input bit ci, input int a,
                                        input int b);
    int r, s, sh;
    bit er, ov, co, gt, lt, eq;
    r = 0; s = 0; er = 0; ov = 0; co = 0; gt = 0; lt = 0; eq = 0;
    sh = b % 8;
    if (m) begin
      case (c)
        0:  begin s = a + b;      r = s; co = (s > 255); end
        1:  begin r = (a - b) & 255; ov = (a < b); end
        2:  begin s = a + b + ci; r = s; co = (s > 255); end
        3:  begin r = (a - b - ci) & 255; ov = (a < b + ci); end
        4:  begin s = a + 1; r = s; co = (s > 255); end
        5:  begin r = (a - 1) & 255; ov = (a == 0); end
        6:  begin s = b + 1; r = s; co = (s > 255); end
        7:  begin r = (b - 1) & 255; ov = (b == 0); end
        8:  begin gt = (a > b); lt = (a < b); eq = (a == b); end
        9:  r = ((a + 1) * (b + 1)) & 'hFFFF;
        10: r = (2 * a * b) & 'hFFFF;
        default: er = 1;
      endcase
    end else begin
      case (c)
        0:  r = a & b;
        1:  r = ~(a & b) & 255;
        2:  r = a | b;
        3:  r = ~(a | b) & 255;
        4:  r = a ^ b;
        5:  r = ~(a ^ b) & 255;
        6:  r = ~a & 255;
        7:  r = ~b & 255;
        8:  r = a >> 1;
        9:  r = (a << 1) & 255;
        10: r = b >> 1;
        11: r = (b << 1) & 255;
        12: begin r = ((a << sh) | (a >> (8 - sh))) & 255; er = (b >= 16); end
        13: begin r = ((a >> sh) | (a << (8 - sh))) & 255; er = (b >= 16); end
        default: er = 1;
      endcase
    end
    return {r[15:0], er, ov, co, gt, lt, eq};
  endfunction

  function automatic logic [1:0] need_of(input bit m, input int c);
    if (m) begin
      if (c <= 3 || c == 8 || c == 9 || c == 10) return 2'b11;
      if (c == 4 || c == 5) return 2'b01;
      if (c == 6 || c == 7) return 2'b10;
      return 2'b00;
    end
    if (c <= 5 || c == 12 || c == 13) return 2'b11;
    if (c == 6 || c == 8 || c == 9) return 2'b01;
    if (c == 7 || c == 10 || c == 11) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit mul_of(input bit m, input int c);
    return m && (c == 9 || c == 10);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit m, input int c, input bit ci,
                       input int a, input int b,
                       input logic [1:0] iv);
    mode      = m;
    cmd       = c[3:0];
    cin       = ci;
    opa       = a[7:0];
    opb       = b[7:0];
    inp_valid = iv;
  endtask

  task automatic junk();
    mode      = 1'($urandom);
    cmd       = 4'($urandom);
    cin       = 1'($urandom);
    opa       = 8'($urandom);
    opb       = 8'($urandom);
    inp_valid = 2'($urandom);
  endtask

  task automatic junk_idle();
    junk();
    inp_valid = 2'b00;
  endtask

  task automatic full_op(input bit m, input int c, input bit ci,
                         input int a, input int b);
    logic [1:0] nd;
    nd = need_of(m, c);
    if (nd == 2'b00 || $urandom_range(0, 1) == 1) nd = 2'b11;
    drive(m, c, ci, a, b, nd);
    tick();
    if (mul_of(m, c)) begin
      junk();
      tick();
    end
    res_chk($sformatf("op_m%0d_c%0d", m, c), model(m, c, ci, a, b));
  endtask

  task automatic split_op(input bit m, input int c, input bit ci,
                          input int a, input int b,
                          input bit b_first, input int gap);
    logic [21:0] exp_v;
    exp_v = model(m, c, ci, a, b);
    drive(m, c, ci, a, b, b_first ? 2'b10 : 2'b01);
    if (b_first) opa = 8'($urandom);
    else         opb = 8'($urandom);
    tick();
    for (int k = 0; k < gap; k++) begin
      junk_idle();
      tick();
    end
    if (gap > 0) chk("split_hold", obs, prev_exp);
    junk();
    if (b_first) opa = a[7:0];
    else         opb = b[7:0];
    if ($urandom_range(0, 1) == 1) inp_valid = 2'b11;
    else                           inp_valid = b_first ? 2'b01 : 2'b10;
    tick();
    if (mul_of(m, c)) begin
      junk();
      tick();
    end
    res_chk($sformatf("split_m%0d_c%0d_gap%0d", m, c, gap), exp_v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int ar2[7] = '{0, 1, 2, 3, 8, 9, 10};
    int lg2[8] = '{0, 1, 2, 3, 4, 5, 12, 13};
    bit m;
    int c;
    rst = 1'b1;
    ce  = 1'b1;
    drive(0, 0, 0, 0, 0, 2'b00);
    tick();
    tick();
    res_chk("reset", 22'h0);
    rst = 1'b0;

    drive(1, 0, 0, 'hFF, 'h01, 2'b11);
    tick();
    res_chk("add_ff_01", {16'h0100, 6'b001000});

    drive(1, 0, 0, 1, 1, 2'b00);
    tick();
    res_chk("idle_no_operand", {16'h0000, 6'b100000});

    drive(1, 9, 0, 3, 4, 2'b11);
    tick();
    drive(1, 0, 0, 'hFF, 'h01, 2'b11);
    tick();
    res_chk("mul_inc_3_4", {16'h0014, 6'b000000});

    drive(1, 0, 0, 5, 0, 2'b01);
    tick();
    for (int k = 0; k < 3; k++) begin
      junk_idle();
      tick();
    end
    junk();
    opb = 8'd7;
    inp_valid = 2'b10;
    tick();
    res_chk("split_5_7", {16'd12, 6'b000000});

    drive(1, 0, 0, 1, 2, 2'b11);
    tick();
    res_chk("add_1_2", {16'd3, 6'b000000});
    drive(1, 0, 0, 5, 0, 2'b01);
    tick();
    for (int k = 0; k < 16; k++) begin
      junk_idle();
      tick();
    end
    chk("timeout_hold", obs, prev_exp);
    tick();
    res_chk("timeout_err", {16'h0000, 6'b100000});

    drive(1, 0, 0, 4, 4, 2'b11);
    tick();
    res_chk("add_4_4", {16'd8, 6'b000000});
    drive(1, 0, 0, 5, 0, 2'b01);
    tick();
    for (int k = 0; k < 3; k++) begin
      junk_idle();
      tick();
    end
    ce = 1'b0;
    drive(1, 0, 0, 1, 1, 2'b11);
    for (int k = 0; k < 5; k++) tick();
    chk("ce_freeze", obs, prev_exp);
    ce = 1'b1;
    for (int k = 0; k < 13; k++) begin
      junk_idle();
      tick();
    end
    chk("ce_timeout_hold", obs, prev_exp);
    tick();
    res_chk("ce_timeout_err", {16'h0000, 6'b100000});

    split_op(1, 0, 0, 200, 100, 1'b0, 16);
    split_op(1, 9, 0, 7, 11, 1'b1, 16);

    drive(1, 8, 0, 9, 9, 2'b11);
    tick();
    res_chk("cmp_9_9", {16'h0000, 6'b000001});
    drive(0, 12, 0, 'h81, 'h01, 2'b11);
    tick();
    res_chk("rol_81_01", {16'h0003, 6'b000000});
    drive(0, 12, 0, 'h81, 'h10, 2'b11);
    tick();
    res_chk("rol_bad_amt", {16'h0081, 6'b100000});

    drive(1, 0, 0, 7, 0, 2'b01);
    tick();
    junk_idle();
    tick();
    rst = 1'b1;
    junk_idle();
    tick();
    res_chk("rst_in_wait", 22'h0);
    rst = 1'b0;
    drive(1, 0, 0, 2, 3, 2'b11);
    tick();
    res_chk("add_after_wait_rst", {16'd5, 6'b000000});

    drive(1, 10, 0, 3, 5, 2'b11);
    tick();
    rst = 1'b1;
    junk();
    tick();
    res_chk("rst_in_mul", 22'h0);
    rst = 1'b0;
    drive(1, 0, 0, 2, 3, 2'b11);
    tick();
    res_chk("add_after_mul_rst", {16'd5, 6'b000000});

    for (int i = 0; i < 300; i++) begin
      full_op(1'($urandom), int'($urandom_range(0, 15)),
              1'($urandom), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)));
    end

    for (int i = 0; i < 60; i++) begin
      m = 1'($urandom);
      c = m ? ar2[$urandom_range(0, 6)] : lg2[$urandom_range(0, 7)];
      split_op(m, c, 1'($urandom), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), 1'($urandom),
               int'($urandom_range(0, 16)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
